// File: rtl/npu_csr_axil_slave.sv
// AXI4-Lite CSR slave for the conv NPU core.
// Holds the layer configuration registers, issues a one-cycle start pulse on
// GO, tracks busy/done and drives a level interrupt from the done flag.
// Only addr[5:2] is decoded; upper and lower address bits alias.
module npu_csr_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  // write response channel
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  // register contents towards the core
  output logic [31:0]                     cfg_cmd,
  output logic [31:0]                     cfg_fram_base,
  output logic [31:0]                     cfg_kram_base,
  output logic [31:0]                     cfg_in_w,
  output logic [31:0]                     cfg_in_h,
  output logic [31:0]                     cfg_in_c,
  output logic [31:0]                     cfg_out_c,
  output logic [31:0]                     cfg_out_base,
  output logic [31:0]                     cfg_out_w,
  output logic [31:0]                     cfg_out_h,
  // core control / status
  output logic                            start,
  input  logic                            compute_done,
  output logic                            busy,
  output logic                            irq
);

  // Word index 0 is CMD, 1..9 are the config registers, 10 is STATUS,
  // 11..15 are unmapped.
  localparam int         NUM_REGS    = 10;
  localparam logic [3:0] IDX_CMD     = 4'd0;
  localparam logic [3:0] IDX_STATUS  = 4'd10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write path holding registers
  logic        aw_full_q, aw_full_d;
  logic [3:0]  aw_idx_q, aw_idx_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  // Read path registers
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  // Register file and core status
  logic [31:0] reg_q [NUM_REGS];
  logic [31:0] reg_d [NUM_REGS];
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_q, start_d;

  // Handshake / decode helpers
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        commit;
  logic        is_cmd, is_cfg, is_status;
  logic        go_req, go_accept;
  logic        done_evt;
  logic        w1c_done;
  logic [31:0] wmask;
  logic [3:0]  ar_idx;
  logic [31:0] rd_val;

  assign aw_hs = s00_axi_awvalid & ~aw_full_q;
  assign w_hs  = s00_axi_wvalid & ~w_full_q;
  assign b_hs  = bvalid_q & s00_axi_bready;
  assign ar_hs = s00_axi_arvalid & ~rvalid_q;
  assign r_hs  = rvalid_q & s00_axi_rready;

  // Both halves latched and no response outstanding: this is the one commit cycle.
  assign commit    = aw_full_q & w_full_q & ~bvalid_q;
  assign is_cmd    = (aw_idx_q == IDX_CMD);
  assign is_cfg    = (aw_idx_q >= 4'd1) && (aw_idx_q <= 4'd9);
  assign is_status = (aw_idx_q == IDX_STATUS);
  assign go_req    = w_strb_q[0] & w_data_q[0];
  assign go_accept = commit & is_cmd & go_req & ~busy_q;
  assign done_evt  = compute_done & busy_q;
  assign w1c_done  = commit & is_status & w_strb_q[0] & w_data_q[1];
  assign ar_idx    = s00_axi_araddr[5:2];

  // Expand the latched byte strobes into a bit mask.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{w_strb_q[gi]}};
    end
  endgenerate

  // AW/W capture, B response generation; channels complete independently.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s00_axi_awaddr[5:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = (is_cfg && busy_q) ? RESP_SLVERR : RESP_OKAY;
    end else if (b_hs) begin
      // Ready lines reopen only once the response has been taken.
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end

  // Register file update: byte-lane merge, GO handling, busy write protect.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_d[i] = reg_q[i];
    end
    // GO self-clears together with the start pulse.
    if (start_q) begin
      reg_d[0][0] = 1'b0;
    end
    if (commit && is_cmd) begin
      reg_d[0] = (reg_q[0] & ~wmask) | (w_data_q & wmask);
      // A GO refused because the core is running is not remembered.
      if (go_req && !go_accept) begin
        reg_d[0][0] = 1'b0;
      end
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (commit && !busy_q && (aw_idx_q == 4'(i))) begin
        reg_d[i] = (reg_q[i] & ~wmask) | (w_data_q & wmask);
      end
    end
  end

  // Core handshake: start/busy on accepted GO, done/irq on completion; set beats W1C.
  always_comb begin
    start_d = go_accept;
    busy_d  = busy_q;
    done_d  = done_q;
    if (go_accept) begin
      busy_d = 1'b1;
    end else if (done_evt) begin
      busy_d = 1'b0;
    end
    if (w1c_done) begin
      done_d = 1'b0;
    end
    if (done_evt) begin
      done_d = 1'b1;
    end
  end

  // Read mux from current register state, so a same-cycle write is not visible.
  always_comb begin
    rd_val = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == 4'(i)) begin
        rd_val = reg_q[i];
      end
    end
    if (ar_idx == IDX_STATUS) begin
      rd_val = {30'h0, done_q, busy_q};
    end
  end

  // Read channel: data captured on the AR handshake, held until rready.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = RESP_OKAY;
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= 4'h0;
      w_full_q  <= 1'b0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= 32'h0;
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

  assign s00_axi_awready = ~aw_full_q;
  assign s00_axi_wready  = ~w_full_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = ~rvalid_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;

  assign cfg_cmd       = reg_q[0];
  assign cfg_fram_base = reg_q[1];
  assign cfg_kram_base = reg_q[2];
  assign cfg_in_w      = reg_q[3];
  assign cfg_in_h      = reg_q[4];
  assign cfg_in_c      = reg_q[5];
  assign cfg_out_c     = reg_q[6];
  assign cfg_out_base  = reg_q[7];
  assign cfg_out_w     = reg_q[8];
  assign cfg_out_h     = reg_q[9];

  assign start = start_q;
  assign busy  = busy_q;
  assign irq   = done_q;

  // Protection bits and undecoded address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:6], s00_axi_awaddr[1:0],
                           s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:6], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_npu_csr_axil_slave.sv
// Self-checking bench for npu_csr_axil_slave: table-driven register
// write/readback plus hand-written sequences for channel ordering, start/done,
// W1C races and asynchronous reset. Responses are checked by a scoreboard.
module tb_npu_csr_axil_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] cfg_cmd, cfg_fram_base, cfg_kram_base, cfg_in_w, cfg_in_h;
  logic [31:0] cfg_in_c, cfg_out_c, cfg_out_base, cfg_out_w, cfg_out_h;
  logic        start;
  logic        compute_done = 1'b0;
  logic        busy;
  logic        irq;

  npu_csr_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .cfg_cmd(cfg_cmd), .cfg_fram_base(cfg_fram_base), .cfg_kram_base(cfg_kram_base),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_in_c(cfg_in_c),
    .cfg_out_c(cfg_out_c), .cfg_out_base(cfg_out_base), .cfg_out_w(cfg_out_w),
    .cfg_out_h(cfg_out_h),
    .start(start), .compute_done(compute_done), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [31:0] cfg_port [10];
  assign cfg_port[0] = cfg_cmd;
  assign cfg_port[1] = cfg_fram_base;
  assign cfg_port[2] = cfg_kram_base;
  assign cfg_port[3] = cfg_in_w;
  assign cfg_port[4] = cfg_in_h;
  assign cfg_port[5] = cfg_in_c;
  assign cfg_port[6] = cfg_out_c;
  assign cfg_port[7] = cfg_out_base;
  assign cfg_port[8] = cfg_out_w;
  assign cfg_port[9] = cfg_out_h;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;
  rexp_t      exp_r[$];
  logic [1:0] exp_b[$];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [31:0] raddr;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count start pulses; a stretched pulse counts more than once.
  always @(negedge clk) begin
    if (!rst && start) start_cnt++;
  end

  // Scoreboard: compare each B and R response as it is accepted.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected: got bresp=%0d expected no response", bresp);
        end else begin
          logic [1:0] eb;
          eb = exp_b.pop_front();
          $display("wr resp bresp=%0d", bresp);
          chk("bresp", 64'(bresp), 64'(eb));
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected: got rdata=0x%0h expected no response", rdata);
        end else begin
          rexp_t er;
          er = exp_r.pop_front();
          $display("rd resp rdata=0x%08h rresp=%0d", rdata, rresp);
          chk("rdata", 64'(rdata), 64'(er.d));
          chk("rresp", 64'(rresp), 64'(er.r));
        end
      end
    end
  end

  // Full write; optionally pulse compute_done during the commit cycle.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] eb, input bit cd);
    int  n;
    bit  hs_aw, hs_w;
    exp_b.push_back(eb);
    awaddr = a; awvalid = 1'b1;
    wdata  = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      n++;
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid  = 1'b0;
    end
    if (awvalid || wvalid) begin
      chk("wr_handshake_timeout", 64'(1), 64'(0));
      awvalid = 1'b0; wvalid = 1'b0;
    end
    if (cd) begin
      compute_done = 1'b1;
      tick();
      compute_done = 1'b0;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    if (!bvalid) chk("bvalid_timeout", 64'(bvalid), 64'(1));
    else tick();
  endtask

  // Read with one-cycle latency check; data checked by the scoreboard.
  task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    exp_r.push_back('{d: ed, r: er});
    araddr = a; arvalid = 1'b1;
    chk("rvalid_before_ar", 64'(rvalid), 64'(0));
    tick();
    arvalid = 1'b0;
    chk("rd_latency", 64'(rvalid), 64'(1));
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_readys"}, 64'({awready, wready, arready}), 64'(3'b111));
    chk({tag, "_flags"}, 64'({bvalid, rvalid, start, busy, irq}), 64'(5'b0));
    chk({tag, "_resp"}, 64'({bresp, rresp}), 64'(4'b0));
    chk({tag, "_rdata"}, 64'(rdata), 64'(0));
    for (int i = 0; i < 10; i++) chk({tag, "_cfg"}, 64'(cfg_port[i]), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cfg_exp [10];
    int base;

    vecs[0]  = '{32'h04,       32'h4200_0000, 4'hF, 2'b00, 32'h04, 32'h4200_0000};
    vecs[1]  = '{32'h08,       32'h4400_0000, 4'hF, 2'b00, 32'h08, 32'h4400_0000};
    vecs[2]  = '{32'h0C,       32'h64,        4'hF, 2'b00, 32'h0C, 32'h64};
    vecs[3]  = '{32'h10,       32'h20,        4'hF, 2'b00, 32'h10, 32'h20};
    vecs[4]  = '{32'h14,       32'h3,         4'hF, 2'b00, 32'h14, 32'h3};
    vecs[5]  = '{32'h18,       32'h1,         4'hF, 2'b00, 32'h18, 32'h1};
    vecs[6]  = '{32'h1C,       32'h4401_0000, 4'hF, 2'b00, 32'h1C, 32'h4401_0000};
    vecs[7]  = '{32'h20,       32'd49,        4'hF, 2'b00, 32'h20, 32'd49};
    vecs[8]  = '{32'h4000_0024, 32'd15,       4'hF, 2'b00, 32'h24, 32'd15};
    vecs[9]  = '{32'h20,       32'hAABB_CCDD, 4'b0010, 2'b00, 32'h20, 32'h0000_CC31};
    vecs[10] = '{32'h30,       32'hFFFF_FFFF, 4'hF, 2'b00, 32'h30, 32'h0};
    vecs[11] = '{32'h28,       32'hFFFF_FFFD, 4'hF, 2'b00, 32'h28, 32'h0};
    vecs[12] = '{32'h3C,       32'h1234_5678, 4'hF, 2'b00, 32'h2C, 32'h0};

    cfg_exp[0] = 32'h0;         cfg_exp[1] = 32'h4200_0000; cfg_exp[2] = 32'h4400_0000;
    cfg_exp[3] = 32'h64;        cfg_exp[4] = 32'h20;        cfg_exp[5] = 32'h3;
    cfg_exp[6] = 32'h1;         cfg_exp[7] = 32'h4401_0000; cfg_exp[8] = 32'h0000_CC31;
    cfg_exp[9] = 32'd15;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick();
    chk_reset_outputs("reset");

    // AW three cycles ahead of W, response held off for five cycles
    exp_b.push_back(2'b00);
    bready = 1'b0;
    awaddr = 32'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("awfirst_awready_low", 64'({awready, wready}), 64'(2'b01));
    tick(); tick();
    wdata = 32'h11; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("awfirst_commit_cycle_bvalid", 64'(bvalid), 64'(0));
    tick();
    chk("awfirst_bvalid", 64'(bvalid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bhold_state", 64'({bvalid, awready, wready}), 64'(3'b100));
    end
    bready = 1'b1;
    tick();
    chk("bhold_release", 64'({bvalid, awready, wready}), 64'(3'b011));

    // W three cycles ahead of AW
    exp_b.push_back(2'b00);
    wdata = 32'h22; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready_low", 64'({awready, wready}), 64'(2'b10));
    tick(); tick();
    awaddr = 32'h1C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_commit_cycle_bvalid", 64'(bvalid), 64'(0));
    tick();
    chk("wfirst_bvalid", 64'(bvalid), 64'(1));
    tick();
    axi_read(32'h18, 32'h11, 2'b00);
    axi_read(32'h1C, 32'h22, 2'b00);

    // Table: write then read back
    for (int i = 0; i < 13; i++) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].bresp, 1'b0);
      axi_read(vecs[i].raddr, vecs[i].rdata, 2'b00);
    end
    for (int i = 0; i < 10; i++) begin
      axi_read(32'(i * 4), cfg_exp[i], 2'b00);
      chk("cfg_port", 64'(cfg_port[i]), 64'(cfg_exp[i]));
    end

    // GO: single start pulse, busy, GO bit self-clears
    base = start_cnt;
    axi_write(32'h00, 32'h0302_FF21, 4'hF, 2'b00, 1'b0);
    tick();
    chk("start_pulses", 64'(start_cnt - base), 64'(1));
    chk("busy_after_go", 64'({start, busy}), 64'(2'b01));
    axi_read(32'h00, 32'h0302_FF20, 2'b00);

    // Config write while busy is refused
    axi_write(32'h0C, 32'h7, 4'hF, 2'b10, 1'b0);
    axi_read(32'h0C, 32'h64, 2'b00);
    chk("in_w_protected", 64'(cfg_in_w), 64'(32'h64));

    // GO while busy is ignored
    base = start_cnt;
    axi_write(32'h00, 32'h21, 4'b0001, 2'b00, 1'b0);
    tick();
    chk("go_while_busy_no_start", 64'(start_cnt - base), 64'(0));
    axi_read(32'h00, 32'h0302_FF20, 2'b00);
    axi_read(32'h28, 32'h1, 2'b00);

    // Completion sets done/irq, W1C clears them
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    chk("done_busy_irq", 64'({busy, irq}), 64'(2'b01));
    axi_read(32'h28, 32'h2, 2'b00);
    axi_write(32'h28, 32'h2, 4'hF, 2'b00, 1'b0);
    chk("w1c_irq", 64'(irq), 64'(0));
    axi_read(32'h28, 32'h0, 2'b00);

    // GO and compute_done in the same cycle: done wins, no new start
    base = start_cnt;
    axi_write(32'h00, 32'h1, 4'b0001, 2'b00, 1'b0);
    tick();
    chk("go2_start", 64'(start_cnt - base), 64'(1));
    base = start_cnt;
    axi_write(32'h00, 32'h1, 4'b0001, 2'b00, 1'b1);
    tick();
    chk("go_cd_no_start", 64'(start_cnt - base), 64'(0));
    chk("go_cd_busy_irq", 64'({busy, irq}), 64'(2'b01));

    // W1C racing compute_done: set wins
    axi_write(32'h00, 32'h1, 4'b0001, 2'b00, 1'b0);
    chk("go3_busy", 64'(busy), 64'(1));
    axi_write(32'h28, 32'h2, 4'hF, 2'b00, 1'b1);
    chk("w1c_cd_irq", 64'({busy, irq}), 64'(2'b01));
    axi_read(32'h28, 32'h2, 2'b00);

    // Asynchronous reset with a response pending and the core busy
    axi_write(32'h00, 32'h1, 4'b0001, 2'b00, 1'b0);
    exp_b.push_back(2'b10);
    bready = 1'b0;
    awaddr = 32'h04; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("pre_reset_state", 64'({bvalid, busy, irq}), 64'(3'b111));
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    exp_b.delete();
    exp_r.delete();
    bready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    axi_read(32'h04, 32'h0, 2'b00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
